apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- APB3 initiator that turns single commands from on-chip control logic into APB transfers on the peripheral bus.
- Peripherals on that bus include the motor H-bridge/PWM register slaves.
- Valid/ready command port in, valid/ready response port out, with an access timeout.
- One transfer outstanding at a time; sits between the robot control sequencer and the APB peripheral bus.

Parameters:
- TIMEOUT_CC, default 255: max ACCESS cycles waiting for PREADY before abort; 0 disables the timeout; legal range 0..65535.
- ADDR_RESET, default 32'h0000_0000: value driven on PADDR after reset.

Ports:
- PCLK  in  1  bus/system clock
- PRESET  in  1  synchronous, active-high reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  command accepted this cycle when CMD_VALID=1
- CMD_WRITE  in  1  1=write, 0=read
- CMD_ADDR  in  32  target APB address
- CMD_WDATA  in  32  write data (ignored for reads)
- RSP_VALID  out  1  response present
- RSP_READY  in  1  response consumed this cycle when RSP_VALID=1
- RSP_RDATA  out  32  read data; 0 for writes and for aborted transfers
- RSP_ERR  out  1  PSLVERR seen or timeout
- RSP_TIMEOUT  out  1  transfer aborted by timeout
- PADDR  out  32  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- Clock and reset: one clock, PCLK; reset PRESET is synchronous and active-high.
- Register outputs: all outputs except CMD_READY are registered.
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=ADDR_RESET, PWDATA=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, RSP_TIMEOUT=0, CMD_READY=0 while PRESET=1; state=IDLE, timeout counter=0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - CMD_READY=1 (combinational from state only, never from CMD_VALID).
  - On CMD_VALID=1, latch CMD_WRITE/ADDR/WDATA into PWRITE/PADDR/PWDATA and go to SETUP.
  - PSEL=0, PENABLE=0; PADDR/PWRITE/PWDATA hold their last values.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS; clear the timeout counter.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR, PWRITE and PWDATA stay stable from SETUP through the last ACCESS cycle.
  - If PREADY=1: capture RSP_RDATA=PWRITE?0:PRDATA, RSP_ERR=PSLVERR, RSP_TIMEOUT=0; go to RESP; next cycle PSEL=0, PENABLE=0, RSP_VALID=1.
  - If PREADY=0: counter increments.
  - If TIMEOUT_CC!=0 and counter==TIMEOUT_CC-1 with PREADY=0: abort; go to RESP with RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0; PSEL/PENABLE drop next cycle.
  - PSLVERR and PRDATA are sampled only on a PREADY=1 cycle.
- RESP:
  - RSP_VALID=1 and response fields stable until RSP_READY=1; backpressure is unlimited.
  - On handshake: RSP_VALID=0 next cycle, go to IDLE.
  - CMD_READY=0 throughout RESP.
- Latency with zero-wait-state slave and RSP_READY tied 1:
  - Cycle 0: command accepted.
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS with PREADY=1.
  - Cycle 3: RSP_VALID=1.
  - Cycle 4: IDLE, next command accepted.
  - Steady-state throughput is one transfer per 4 cycles.
- Wait states: each PREADY=0 cycle in ACCESS adds one cycle to latency.
- Timeout boundary: with TIMEOUT_CC=N, the number of ACCESS cycles is exactly N on abort; PREADY=1 on cycle N completes normally (not a timeout).
- Commands outside IDLE: CMD_VALID is ignored in SETUP/ACCESS/RESP; no command is lost because CMD_READY=0.
- Reset mid-transfer: PRESET in any state forces the reset values at the next edge; no response is issued for the aborted command.
- Counter: 16-bit, saturating; compared only when TIMEOUT_CC!=0.

Test Plan:
- Write, zero wait: CMD write PADDR=0x0008, PWDATA=5000, PREADY=1 → PSEL 1 for 2 cycles, PENABLE 1 on the 2nd, PWRITE=1; RSP_VALID on cycle 3 with RDATA=0, ERR=0.
- Read with waits: CMD read 0x000C, slave holds PREADY=0 for 3 ACCESS cycles, then PREADY=1 with PRDATA=0x0000_09C4 → 5 ACCESS-phase cycles total including SETUP; RSP_RDATA=0x9C4; PADDR stable throughout.
- Slave error: read with PREADY=1, PSLVERR=1 → RSP_ERR=1, RSP_TIMEOUT=0; PSLVERR=1 while PREADY=0 earlier is ignored.
- Timeout, TIMEOUT_CC=8: PREADY held 0 → exactly 8 ACCESS cycles, then RSP_ERR=1, RSP_TIMEOUT=1, RDATA=0. Repeat with PREADY=1 on the 8th ACCESS cycle → normal completion.
- Backpressure: RSP_READY=0 for 10 cycles with CMD_VALID=1 held → RSP fields stable, CMD_READY=0, no new PSEL. After RSP_READY=1, the next command is accepted 1 cycle later.
- Reset mid-ACCESS: PRESET=1 during ACCESS → next edge PSEL=0, PENABLE=0, PADDR=ADDR_RESET, RSP_VALID=0; no response after reset release; a new command completes normally.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// Command/response and APB3 signal bundle for apb_cmd_master.
// The master modport is the initiator view; slave is the view for the bus and command side.
interface apb_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one command in flight, 4 cycles per zero-wait transfer, optional access timeout.
// cmd_ready only in IDLE; the response is held unchanged until rsp_ready, with no stall limit.
module apb_cmd_master #(
    parameter int unsigned TIMEOUT_CC = 255,
    parameter logic [31:0] ADDR_RESET = 32'h0000_0000
) (
    input logic                  i_pclk,
    input logic                  i_preset,
    apb_cmd_master_if.master     if_bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT_CC != 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CC - 1) : 16'd0;

    state_t      r_state,       w_state;
    logic [15:0] r_cnt,         w_cnt;
    logic        r_psel,        w_psel;
    logic        r_penable,     w_penable;
    logic        r_pwrite,      w_pwrite;
    logic [31:0] r_paddr,       w_paddr;
    logic [31:0] r_pwdata,      w_pwdata;
    logic        r_rsp_valid,   w_rsp_valid;
    logic [31:0] r_rsp_rdata,   w_rsp_rdata;
    logic        r_rsp_err,     w_rsp_err;
    logic        r_rsp_timeout, w_rsp_timeout;

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= ADDR_RESET;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_psel        <= w_psel;
            r_penable     <= w_penable;
            r_pwrite      <= w_pwrite;
            r_paddr       <= w_paddr;
            r_pwdata      <= w_pwdata;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_err     <= w_rsp_err;
            r_rsp_timeout <= w_rsp_timeout;
        end
    end

    // Next-state logic computes next register values so every bus/response output is a flop.
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_psel        = r_psel;
        w_penable     = r_penable;
        w_pwrite      = r_pwrite;
        w_paddr       = r_paddr;
        w_pwdata      = r_pwdata;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_err     = r_rsp_err;
        w_rsp_timeout = r_rsp_timeout;

        case (r_state)
            ST_IDLE: begin
                if (if_bus.cmd_valid) begin
                    w_pwrite  = if_bus.cmd_write;
                    w_paddr   = if_bus.cmd_addr;
                    w_pwdata  = if_bus.cmd_wdata;
                    w_psel    = 1'b1;
                    w_penable = 1'b0;
                    w_state   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_penable = 1'b1;
                w_cnt     = '0;
                w_state   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (if_bus.pready) begin
                    w_rsp_rdata   = r_pwrite ? 32'h0 : if_bus.prdata;
                    w_rsp_err     = if_bus.pslverr;
                    w_rsp_timeout = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_state       = ST_RESP;
                end else if (TO_EN && (r_cnt == TO_LAST)) begin
                    // Counter holds the number of ACCESS cycles already spent, so this is cycle N.
                    w_rsp_rdata   = 32'h0;
                    w_rsp_err     = 1'b1;
                    w_rsp_timeout = 1'b1;
                    w_rsp_valid   = 1'b1;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_state       = ST_RESP;
                end else if (r_cnt != 16'hFFFF) begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            ST_RESP: begin
                if (if_bus.rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_state     = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign if_bus.cmd_ready   = (r_state == ST_IDLE) && !i_preset;
    assign if_bus.psel        = r_psel;
    assign if_bus.penable     = r_penable;
    assign if_bus.pwrite      = r_pwrite;
    assign if_bus.paddr       = r_paddr;
    assign if_bus.pwdata      = r_pwdata;
    assign if_bus.rsp_valid   = r_rsp_valid;
    assign if_bus.rsp_rdata   = r_rsp_rdata;
    assign if_bus.rsp_err     = r_rsp_err;
    assign if_bus.rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed scenarios plus randomized transfers against a transaction-level model.
module tb_apb_cmd_master;
    localparam int          TMO      = 8;
    localparam logic [31:0] ADDR_RST = 32'hA5A5_0000;

    logic clk;
    logic preset;
    int   checks;
    int   errors;

    apb_cmd_master_if bus ();

    apb_cmd_master #(
        .TIMEOUT_CC (TMO),
        .ADDR_RESET (ADDR_RST)
    ) dut (
        .i_pclk   (clk),
        .i_preset (preset),
        .if_bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          ready0;
        int          setup_cnt;
        int          access_cnt;
        int          rsp_cycle;
        int          done_cycle;
        bit          addr_bad;
        bit          rsp_unstable;
        bit          bp_bad;
        bit          hung;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        logic [31:0] idle_paddr;
    } obs_t;

    typedef struct {
        int          acc;
        bit          tmo;
        bit          err;
        logic [31:0] rdata;
        int          rsp_cycle;
        int          done_cycle;
    } exp_t;

    // Transaction-level expectation: how many ACCESS cycles, whether it times out, what comes back.
    function automatic exp_t model(bit wr, int waits, logic [31:0] rdat, bit serr, int bp);
        exp_t e;
        e.tmo        = (TMO != 0) && (waits >= TMO);
        e.acc        = e.tmo ? TMO : waits + 1;
        e.err        = e.tmo || serr;
        e.rdata      = (e.tmo || wr) ? 32'h0 : rdat;
        e.rsp_cycle  = 2 + e.acc;
        e.done_cycle = e.rsp_cycle + bp + 1;
        return e;
    endfunction

    // Drives one command and plays the slave; records what it saw without judging it.
    // Must be entered just after a falling edge.
    task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] rdat, input bit serr,
                           input bit early_err, input int bp, input bit hold, output obs_t o);
        int cyc;
        int acc;
        int rsp_n;
        bit handshake;
        o = '{default: 0};
        o.done_cycle = -1;
        o.ready0 = int'(bus.cmd_ready);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        cyc = 0; acc = 0; rsp_n = 0; handshake = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (!hold) bus.cmd_valid = 1'b0;
            if (handshake) begin
                if (!bus.rsp_valid && bus.cmd_ready) o.done_cycle = cyc;
                o.idle_paddr  = bus.paddr;
                bus.rsp_ready = 1'b0;
                break;
            end
            if (bus.psel && !bus.penable) o.setup_cnt++;
            if (bus.psel && (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== wdata))
                o.addr_bad = 1'b1;
            if (bus.psel && bus.penable) begin
                acc++;
                o.access_cnt = acc;
                bus.pready  = (acc > waits);
                bus.prdata  = bus.pready ? rdat : $urandom;
                bus.pslverr = bus.pready ? serr : early_err;
            end else begin
                bus.pready  = 1'b0;
                bus.pslverr = 1'b0;
                bus.prdata  = $urandom;
            end
            if (bus.rsp_valid) begin
                rsp_n++;
                if (rsp_n == 1) begin
                    o.rsp_cycle = cyc;
                    o.rdata     = bus.rsp_rdata;
                    o.err       = bus.rsp_err;
                    o.tmo       = bus.rsp_timeout;
                end else if (bus.rsp_rdata !== o.rdata || bus.rsp_err !== o.err ||
                             bus.rsp_timeout !== o.tmo) begin
                    o.rsp_unstable = 1'b1;
                end
                if (bus.cmd_ready || bus.psel) o.bp_bad = 1'b1;
                bus.rsp_ready = (rsp_n > bp);
                handshake     = bus.rsp_ready;
            end
            if (cyc > 400) begin
                o.hung = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        bus.cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.psel !== 1'b0) begin errors++; $display("FAIL rst_psel got %b want 0", bus.psel); end
        checks++; if (bus.penable !== 1'b0) begin errors++; $display("FAIL rst_penable got %b want 0", bus.penable); end
        checks++; if (bus.pwrite !== 1'b0) begin errors++; $display("FAIL rst_pwrite got %b want 0", bus.pwrite); end
        checks++; if (bus.paddr !== ADDR_RST) begin errors++; $display("FAIL rst_paddr got %h want %h", bus.paddr, ADDR_RST); end
        checks++; if (bus.pwdata !== 32'h0) begin errors++; $display("FAIL rst_pwdata got %h want 0", bus.pwdata); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata got %h want 0", bus.rsp_rdata); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b want 0", bus.rsp_err); end
        checks++; if (bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL rst_rsp_timeout got %b want 0", bus.rsp_timeout); end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b want 0", bus.cmd_ready); end
        bus.cmd_valid = 1'b0;
        preset = 1'b0;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_write_zero_wait();
        obs_t o;
        do_xfer(1'b1, 32'h0000_0008, 32'd5000, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1'b0, o);
        checks++; if (o.ready0 !== 1) begin errors++; $display("FAIL wr_ready0 got %0d want 1", o.ready0); end
        checks++; if (o.setup_cnt !== 1) begin errors++; $display("FAIL wr_setup got %0d want 1", o.setup_cnt); end
        checks++; if (o.access_cnt !== 1) begin errors++; $display("FAIL wr_access got %0d want 1", o.access_cnt); end
        checks++; if (o.addr_bad !== 1'b0) begin errors++; $display("FAIL wr_bus_fields got %b want 0", o.addr_bad); end
        checks++; if (o.rsp_cycle !== 3) begin errors++; $display("FAIL wr_rsp_cycle got %0d want 3", o.rsp_cycle); end
        checks++; if (o.rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h want 0", o.rdata); end
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", o.err); end
        checks++; if (o.done_cycle !== 4) begin errors++; $display("FAIL wr_done got %0d want 4", o.done_cycle); end
        checks++; if (o.idle_paddr !== 32'h0000_0008) begin errors++; $display("FAIL wr_idle_paddr got %h want 8", o.idle_paddr); end
    endtask

    task automatic test_read_waits();
        obs_t o;
        do_xfer(1'b0, 32'h0000_000C, 32'h1234_5678, 3, 32'h0000_09C4, 1'b0, 1'b0, 0, 1'b0, o);
        checks++; if (o.setup_cnt + o.access_cnt !== 5) begin errors++; $display("FAIL rdw_phase_cycles got %0d want 5", o.setup_cnt + o.access_cnt); end
        checks++; if (o.addr_bad !== 1'b0) begin errors++; $display("FAIL rdw_paddr_stable got %b want 0", o.addr_bad); end
        checks++; if (o.rdata !== 32'h0000_09C4) begin errors++; $display("FAIL rdw_rdata got %h want 9c4", o.rdata); end
        checks++; if (o.rsp_cycle !== 6) begin errors++; $display("FAIL rdw_rsp_cycle got %0d want 6", o.rsp_cycle); end
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL rdw_err got %b want 0", o.err); end
    endtask

    task automatic test_slave_error();
        obs_t o;
        do_xfer(1'b0, 32'h0000_0010, 32'h0, 2, 32'h0000_0077, 1'b1, 1'b1, 0, 1'b0, o);
        checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL serr_err got %b want 1", o.err); end
        checks++; if (o.tmo !== 1'b0) begin errors++; $display("FAIL serr_tmo got %b want 0", o.tmo); end
        checks++; if (o.rdata !== 32'h0000_0077) begin errors++; $display("FAIL serr_rdata got %h want 77", o.rdata); end
        do_xfer(1'b0, 32'h0000_0014, 32'h0, 2, 32'h0000_0055, 1'b0, 1'b1, 0, 1'b0, o);
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL serr_early_ignored got %b want 0", o.err); end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_xfer(1'b0, 32'h0000_0020, 32'h0, 1000, 32'hCAFE_F00D, 1'b0, 1'b1, 0, 1'b0, o);
        checks++; if (o.access_cnt !== TMO) begin errors++; $display("FAIL tmo_access got %0d want %0d", o.access_cnt, TMO); end
        checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", o.err); end
        checks++; if (o.tmo !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b want 1", o.tmo); end
        checks++; if (o.rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata got %h want 0", o.rdata); end
        checks++; if (o.hung !== 1'b0) begin errors++; $display("FAIL tmo_hung got %b want 0", o.hung); end
        do_xfer(1'b0, 32'h0000_0024, 32'h0, TMO - 1, 32'h0BAD_CAFE, 1'b0, 1'b0, 0, 1'b0, o);
        checks++; if (o.access_cnt !== TMO) begin errors++; $display("FAIL edge_access got %0d want %0d", o.access_cnt, TMO); end
        checks++; if (o.tmo !== 1'b0) begin errors++; $display("FAIL edge_tmo got %b want 0", o.tmo); end
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL edge_err got %b want 0", o.err); end
        checks++; if (o.rdata !== 32'h0BAD_CAFE) begin errors++; $display("FAIL edge_rdata got %h want 0badcafe", o.rdata); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        do_xfer(1'b0, 32'h0000_0030, 32'h0, 1, 32'h0000_4321, 1'b0, 1'b0, 10, 1'b1, o);
        checks++; if (o.rsp_unstable !== 1'b0) begin errors++; $display("FAIL bp_stable got %b want 0", o.rsp_unstable); end
        checks++; if (o.bp_bad !== 1'b0) begin errors++; $display("FAIL bp_ready_psel got %b want 0", o.bp_bad); end
        checks++; if (o.setup_cnt !== 1) begin errors++; $display("FAIL bp_setup got %0d want 1", o.setup_cnt); end
        checks++; if (o.rdata !== 32'h0000_4321) begin errors++; $display("FAIL bp_rdata got %h want 4321", o.rdata); end
        checks++; if (o.done_cycle !== o.rsp_cycle + 11) begin errors++; $display("FAIL bp_done got %0d want %0d", o.done_cycle, o.rsp_cycle + 11); end
        do_xfer(1'b1, 32'h0000_0034, 32'h0000_00AA, 0, 32'h0, 1'b0, 1'b0, 0, 1'b0, o);
        checks++; if (o.ready0 !== 1) begin errors++; $display("FAIL bp_next_ready got %0d want 1", o.ready0); end
        checks++; if (o.rsp_cycle !== 3) begin errors++; $display("FAIL bp_next_rsp got %0d want 3", o.rsp_cycle); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        for (int i = 0; i < 4; i++) begin
            do_xfer(1'b0, 32'h100 + 32'(i * 4), 32'h0, 0, 32'h5000 + 32'(i), 1'b0, 1'b0, 0, 1'b0, o);
            checks++; if (o.ready0 !== 1) begin errors++; $display("FAIL b2b_ready%0d got %0d want 1", i, o.ready0); end
            checks++; if (o.done_cycle !== 4) begin errors++; $display("FAIL b2b_done%0d got %0d want 4", i, o.done_cycle); end
            checks++; if (o.rdata !== 32'h5000 + 32'(i)) begin errors++; $display("FAIL b2b_rdata%0d got %h want %h", i, o.rdata, 32'h5000 + 32'(i)); end
        end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        for (int i = 0; i < 25; i++) begin
            bit          wr    = 1'($urandom_range(0, 1));
            logic [31:0] addr  = $urandom & 32'hFFFF_FFFC;
            logic [31:0] wdata = $urandom;
            logic [31:0] rdat  = $urandom;
            int          waits = int'($urandom_range(0, 11));
            bit          serr  = 1'($urandom_range(0, 1));
            bit          eerr  = 1'($urandom_range(0, 1));
            int          bp    = int'($urandom_range(0, 3));
            e = model(wr, waits, rdat, serr, bp);
            do_xfer(wr, addr, wdata, waits, rdat, serr, eerr, bp, 1'b0, o);
            checks++; if (o.access_cnt !== e.acc) begin errors++; $display("FAIL rnd%0d_access got %0d want %0d", i, o.access_cnt, e.acc); end
            checks++; if (o.rsp_cycle !== e.rsp_cycle) begin errors++; $display("FAIL rnd%0d_rsp_cycle got %0d want %0d", i, o.rsp_cycle, e.rsp_cycle); end
            checks++; if (o.done_cycle !== e.done_cycle) begin errors++; $display("FAIL rnd%0d_done got %0d want %0d", i, o.done_cycle, e.done_cycle); end
            checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", i, o.rdata, e.rdata); end
            checks++; if (o.err !== e.err) begin errors++; $display("FAIL rnd%0d_err got %b want %b", i, o.err, e.err); end
            checks++; if (o.tmo !== e.tmo) begin errors++; $display("FAIL rnd%0d_tmo got %b want %b", i, o.tmo, e.tmo); end
            checks++; if (o.addr_bad !== 1'b0) begin errors++; $display("FAIL rnd%0d_bus_fields got %b want 0", i, o.addr_bad); end
            checks++; if (o.rsp_unstable !== 1'b0) begin errors++; $display("FAIL rnd%0d_stable got %b want 0", i, o.rsp_unstable); end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   n;
        bit   seen;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0000_0040;
        bus.cmd_wdata = 32'h0;
        bus.pready    = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!(bus.psel && bus.penable) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (!(bus.psel && bus.penable)) begin errors++; $display("FAIL rmid_reach_access got %b%b want 11", bus.psel, bus.penable); end
        preset = 1'b1;
        @(negedge clk);
        checks++; if (bus.psel !== 1'b0) begin errors++; $display("FAIL rmid_psel got %b want 0", bus.psel); end
        checks++; if (bus.penable !== 1'b0) begin errors++; $display("FAIL rmid_penable got %b want 0", bus.penable); end
        checks++; if (bus.paddr !== ADDR_RST) begin errors++; $display("FAIL rmid_paddr got %h want %h", bus.paddr, ADDR_RST); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp_valid got %b want 0", bus.rsp_valid); end
        preset = 1'b0;
        seen = 1'b0;
        bus.pready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.psel) seen = 1'b1;
        end
        bus.pready = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp got %b want 0", seen); end
        do_xfer(1'b1, 32'h0000_0044, 32'h0000_1111, 0, 32'h0, 1'b0, 1'b0, 0, 1'b0, o);
        checks++; if (o.rsp_cycle !== 3) begin errors++; $display("FAIL rmid_after_rsp got %0d want 3", o.rsp_cycle); end
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL rmid_after_err got %b want 0", o.err); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        preset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = 32'h0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_slave_error();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
